slave_tx_packer: RTL and testbench

- Sits downstream of the functional-test and peripheral channels.
- Scans the 5-channel `have_msg_bus`, grants one channel at a time in round-robin order, and drains that channel's slave FIFO.
- Wraps the drained bytes into a framed packet (sync, address, length, payload, checksum) and presents it on a byte stream with a valid/ready handshake toward the host-link transmitter.
- All logic is in the `sys_clk` domain, the same domain as the slave FIFO read ports.

---
 rtl/func_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/slave_tx_packer.sv | 130 +++++++++++++
 tb/tb_slave_tx_packer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/func_pkg.sv
// Shared types and constants for the slave transmit packer.
package func_pkg;

    localparam int         CH_W          = 3;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ADDR,
        LEN,
        FETCH,
        LATCH,
        SEND,
        CSUM
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_CH = 5,
    parameter int CH_W = 3
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            gnt_valid,
    output logic [CH_W-1:0] gnt_idx
);

    logic [N_CH-1:0] rot;
    logic [CH_W:0]   sum;

    always_comb begin
        // bit i of rot is req[(ptr + i) mod N_CH]
        rot       = N_CH'({req, req} >> ptr);
        gnt_valid = |rot;
        sum       = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr} + (CH_W + 1)'(i);
            end
        end
        if (sum >= (CH_W + 1)'(N_CH)) begin
            sum = sum - (CH_W + 1)'(N_CH);
        end
        gnt_idx = sum[CH_W-1:0];
    end

endmodule

// File: rtl/slave_tx_packer.sv
// Round-robin drains per-channel slave FIFOs into framed packets:
// sync, address, length, payload, 8-bit additive checksum (sync excluded).
module slave_tx_packer
    import func_pkg::*;
#(
    parameter int         N_CH      = 5,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              sys_clk,
    input  logic              n_rst,
    input  logic [N_CH-1:0]   have_msg_bus,
    input  logic [8*N_CH-1:0] len_bus,
    input  logic [8*N_CH-1:0] slave_data_bus,
    output logic [N_CH-1:0]   rdreq_bus,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [CH_W-1:0]   cur_chan
);

    state_t          state;
    logic [CH_W-1:0] rr_ptr;
    logic [7:0]      count;
    logic [7:0]      checksum;
    logic [N_CH-1:0] pending;
    logic            gnt_valid;
    logic [CH_W-1:0] gnt_idx;
    logic [7:0]      gnt_len;
    logic [7:0]      rd_byte;
    logic            hs;
    logic [CH_W-1:0] next_ptr;
    logic [N_CH-1:0] rd_onehot;

    always_comb begin
        pending = '0;
        gnt_len = '0;
        rd_byte = '0;
        for (int k = 0; k < N_CH; k++) begin
            pending[k] = have_msg_bus[k] & (|len_bus[8*k +: 8]);
            if (gnt_idx == CH_W'(k)) gnt_len = len_bus[8*k +: 8];
            if (cur_chan == CH_W'(k)) rd_byte = slave_data_bus[8*k +: 8];
        end
    end

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req       (pending),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign hs        = tx_valid & tx_ready;
    assign next_ptr  = (cur_chan == CH_W'(N_CH - 1)) ? '0 : cur_chan + 1'b1;
    assign rd_onehot = {{(N_CH-1){1'b0}}, 1'b1} << cur_chan;

    // Valid/ready: a byte moves on a cycle where tx_valid & tx_ready; tx_data is frozen
    // while tx_valid is high and not yet accepted. tx_ready is don't-care while tx_valid=0.
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            count     <= '0;
            checksum  <= '0;
            cur_chan  <= '0;
            rdreq_bus <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rdreq_bus <= '0;
            case (state)
                IDLE: if (gnt_valid) begin
                    cur_chan <= gnt_idx;
                    count    <= gnt_len;
                    checksum <= '0;
                    tx_data  <= SYNC_BYTE;
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                    state    <= SYNC;
                end
                SYNC: if (hs) begin
                    tx_data <= {{(8-CH_W){1'b0}}, cur_chan};
                    state   <= ADDR;
                end
                ADDR: if (hs) begin
                    checksum <= checksum + tx_data;
                    tx_data  <= count;
                    state    <= LEN;
                end
                LEN: if (hs) begin
                    checksum  <= checksum + tx_data;
                    tx_valid  <= 1'b0;
                    rdreq_bus <= rd_onehot;
                    state     <= FETCH;
                end
                FETCH: state <= LATCH;
                // FIFO is non-show-ahead: data for the FETCH strobe is on the bus now
                LATCH: begin
                    tx_data  <= rd_byte;
                    checksum <= checksum + rd_byte;
                    count    <= count - 8'd1;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: if (hs) begin
                    if (count != 8'd0) begin
                        tx_valid  <= 1'b0;
                        rdreq_bus <= rd_onehot;
                        state     <= FETCH;
                    end else begin
                        tx_data <= checksum;
                        state   <= CSUM;
                    end
                end
                CSUM: if (hs) begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    rr_ptr   <= next_ptr;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_tx_packer.sv
// Randomised bench for slave_tx_packer: packet-level reference model checked every cycle.
module tb_slave_tx_packer;

    localparam int N_CH = 5;

    logic              sys_clk = 1'b0;
    logic              n_rst = 1'b0;
    logic [N_CH-1:0]   have_msg_bus = '0;
    logic [8*N_CH-1:0] len_bus = '0;
    logic [8*N_CH-1:0] slave_data_bus = '0;
    logic [N_CH-1:0]   rdreq_bus;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              busy;
    logic [2:0]        cur_chan;

    always #5 sys_clk = ~sys_clk;

    slave_tx_packer #(.N_CH(N_CH), .SYNC_BYTE(8'hAA)) dut (
        .sys_clk        (sys_clk),
        .n_rst          (n_rst),
        .have_msg_bus   (have_msg_bus),
        .len_bus        (len_bus),
        .slave_data_bus (slave_data_bus),
        .rdreq_bus      (rdreq_bus),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .cur_chan       (cur_chan)
    );

    int checks = 0;
    int passed = 0;

    // reference model state
    bit         idle_m = 1'b1;
    int         ch_m = 0, len_m = 0, pos_m = 0, gap_m = 0, rr_m = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo[N_CH][$];
    logic [7:0] acc_q[$];
    int         acc_cyc_q[$];
    int         grant_q[$];
    int         rd_cnt[N_CH];
    int         cyc = 0;
    int         grant_cyc = 0;

    bit   ready_rand = 1'b0;
    logic ready_val = 1'b1;
    bit   clear_on_grant = 1'b0;
    bit   clear_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit model_valid();
        return !idle_m && gap_m == 0;
    endfunction

    task automatic check_outputs();
        logic [N_CH-1:0] exp_rd;
        exp_rd = (!idle_m && gap_m == 2) ? (N_CH'(1) << ch_m) : '0;
        check("busy", busy, !idle_m);
        check("tx_valid", tx_valid, model_valid());
        check("rdreq_bus", rdreq_bus, exp_rd);
        if (model_valid() && exp_q.size() > 0) check("tx_data", tx_data, exp_q[0]);
        if (!idle_m) check("cur_chan", cur_chan, ch_m);
    endtask

    task automatic drive();
        tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
        if (clear_pending) begin
            have_msg_bus  = '0;
            clear_pending = 1'b0;
        end
        for (int k = 0; k < N_CH; k++) begin
            if (rdreq_bus[k]) begin
                rd_cnt[k]++;
                slave_data_bus[8*k +: 8] = fifo[k].pop_front();
            end
            while (fifo[k].size() < 16) fifo[k].push_back(8'($urandom_range(0, 255)));
        end
    endtask

    // predicts what the coming rising edge does, from the inputs now on the pins
    task automatic predict();
        bit         hs, was_idle, found;
        int         k, sel;
        logic [7:0] b, cs, l;
        hs       = model_valid() && tx_ready;
        was_idle = idle_m;
        found    = 1'b0;
        sel      = 0;
        if (gap_m > 0) gap_m--;
        if (hs) begin
            b = exp_q.pop_front();
            acc_q.push_back(b);
            acc_cyc_q.push_back(cyc);
            if (pos_m >= 2 && pos_m < 2 + len_m) gap_m = 2;
            if (pos_m == 3 + len_m) begin
                idle_m = 1'b1;
                rr_m   = (ch_m + 1) % N_CH;
            end
            pos_m++;
        end
        if (was_idle) begin
            for (int i = 0; i < N_CH; i++) begin
                k = (rr_m + i) % N_CH;
                if (!found && have_msg_bus[k] && len_bus[8*k +: 8] != 8'd0) begin
                    found = 1'b1;
                    sel   = k;
                end
            end
            if (found) begin
                l = len_bus[8*sel +: 8];
                exp_q.delete();
                exp_q.push_back(8'hAA);
                exp_q.push_back(8'(sel));
                exp_q.push_back(l);
                cs = 8'(sel) + l;
                for (int j = 0; j < int'(l); j++) begin
                    exp_q.push_back(fifo[sel][j]);
                    cs = cs + fifo[sel][j];
                end
                exp_q.push_back(cs);
                idle_m    = 1'b0;
                pos_m     = 0;
                ch_m      = sel;
                len_m     = int'(l);
                grant_cyc = cyc + 1;
                grant_q.push_back(sel);
                if (clear_on_grant) clear_pending = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic tick_a();
        @(negedge sys_clk);
        check_outputs();
    endtask

    task automatic tick_b();
        drive();
        predict();
    endtask

    task automatic step();
        tick_a();
        tick_b();
    endtask

    task automatic run_packet(input int budget);
        bit started, done;
        started = !idle_m;
        done    = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            step();
            if (!idle_m) started = 1'b1;
            if (started && idle_m) done = 1'b1;
        end
        check("packet_done", done, 1'b1);
    endtask

    logic [7:0] lit1[7] = '{8'hAA, 8'h04, 8'h03, 8'h01, 8'h02, 8'h03, 8'h0D};
    logic [7:0] bp_data[4];
    logic [7:0] stream_a[$];
    logic [7:0] bp_sum;
    bit         rst_hit;
    int         ngrant;

    initial begin
        for (int k = 0; k < N_CH; k++) begin
            rd_cnt[k] = 0;
            while (fifo[k].size() < 16) fifo[k].push_back(8'($urandom_range(0, 255)));
        end

        // reset values
        #12;
        check("rst_rdreq", rdreq_bus, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_chan", cur_chan, 0);
        @(negedge sys_clk);
        n_rst = 1'b1;
        tick_b();
        repeat (3) step();

        // single packet ch4 len=3
        tick_a();
        fifo[4].delete();
        fifo[4].push_back(8'h01); fifo[4].push_back(8'h02); fifo[4].push_back(8'h03);
        len_bus[8*4 +: 8] = 8'd3;
        have_msg_bus = 5'b10000;
        clear_on_grant = 1'b1;
        acc_q.delete(); acc_cyc_q.delete();
        for (int k = 0; k < N_CH; k++) rd_cnt[k] = 0;
        tick_b();
        run_packet(100);
        check("single_len", acc_q.size(), 7);
        for (int i = 0; i < 7 && i < acc_q.size(); i++) check("single_byte", acc_q[i], lit1[i]);
        if (acc_cyc_q.size() > 0) check("single_cycles", acc_cyc_q[$] - grant_cyc + 1, 13);
        step();
        step();
        check("single_rdreq4", rd_cnt[4], 3);
        check("single_busy_after", busy, 0);

        // round robin ch1/ch3
        tick_a();
        len_bus[8*1 +: 8] = 8'd1;
        len_bus[8*3 +: 8] = 8'd1;
        have_msg_bus = 5'b01010;
        clear_on_grant = 1'b0;
        grant_q.delete();
        tick_b();
        repeat (4) run_packet(100);
        tick_a();
        have_msg_bus = '0;
        tick_b();
        check("rr_count", grant_q.size(), 4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++) check("rr_order", grant_q[i], (i % 2 == 0) ? 1 : 3);
        for (int i = 1; i < grant_q.size(); i++) check("rr_no_repeat", grant_q[i] != grant_q[i-1], 1);

        // backpressure ch2 len=4, then the same data with tx_ready=1
        for (int i = 0; i < 4; i++) bp_data[i] = 8'($urandom_range(0, 255));
        bp_sum = 8'h02 + 8'h04 + bp_data[0] + bp_data[1] + bp_data[2] + bp_data[3];
        tick_a();
        fifo[2].delete();
        for (int i = 0; i < 4; i++) fifo[2].push_back(bp_data[i]);
        len_bus[8*2 +: 8] = 8'd4;
        have_msg_bus = 5'b00100;
        clear_on_grant = 1'b1;
        ready_rand = 1'b1;
        acc_q.delete();
        tick_b();
        run_packet(300);
        stream_a = acc_q;
        tick_a();
        fifo[2].delete();
        for (int i = 0; i < 4; i++) fifo[2].push_back(bp_data[i]);
        have_msg_bus = 5'b00100;
        ready_rand = 1'b0;
        acc_q.delete();
        tick_b();
        run_packet(100);
        check("bp_len", stream_a.size(), 8);
        check("bp_len_b", acc_q.size(), 8);
        for (int i = 0; i < 8 && i < stream_a.size() && i < acc_q.size(); i++)
            check("bp_same", stream_a[i], acc_q[i]);
        if (stream_a.size() == 8) check("bp_csum", stream_a[7], bp_sum);

        // zero length never granted
        tick_a();
        len_bus[8*2 +: 8] = 8'd0;
        have_msg_bus = 5'b00100;
        ngrant = grant_q.size();
        tick_b();
        repeat (20) step();
        check("zero_len_grants", grant_q.size(), ngrant);
        check("zero_len_busy", busy, 0);

        // ch0 len=2, have dropped after grant
        tick_a();
        len_bus[8*0 +: 8] = 8'd2;
        have_msg_bus = 5'b00001;
        clear_on_grant = 1'b1;
        acc_q.delete();
        tick_b();
        run_packet(100);
        check("drop_len", acc_q.size(), 6);
        if (acc_q.size() == 6) begin
            check("drop_addr", acc_q[1], 8'h00);
            check("drop_lenbyte", acc_q[2], 8'h02);
        end

        // checksum wrap
        tick_a();
        fifo[4].delete();
        fifo[4].push_back(8'hFF); fifo[4].push_back(8'hFF);
        len_bus[8*4 +: 8] = 8'd2;
        have_msg_bus = 5'b10000;
        acc_q.delete();
        tick_b();
        run_packet(100);
        check("wrap_len", acc_q.size(), 6);
        if (acc_q.size() == 6) check("wrap_csum", acc_q[5], 8'h04);

        // reset during SEND of payload byte 2
        tick_a();
        fifo[4].delete();
        fifo[4].push_back(8'h10); fifo[4].push_back(8'h20); fifo[4].push_back(8'h30);
        len_bus[8*4 +: 8] = 8'd3;
        have_msg_bus = 5'b10000;
        clear_on_grant = 1'b0;
        tick_b();
        rst_hit = 1'b0;
        for (int n = 0; n < 100 && !rst_hit; n++) begin
            step();
            if (!idle_m && pos_m == 4 && gap_m == 0) rst_hit = 1'b1;
        end
        check("rst_reached_send", rst_hit, 1'b1);
        @(posedge sys_clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_rdreq", rdreq_bus, 0);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cur_chan", cur_chan, 0);
        idle_m = 1'b1; gap_m = 0; pos_m = 0; rr_m = 0; exp_q.delete();
        @(negedge sys_clk);
        @(negedge sys_clk);
        n_rst = 1'b1;
        clear_on_grant = 1'b1;
        acc_q.delete();
        tick_b();
        run_packet(100);
        check("midrst_new_len", acc_q.size(), 7);
        if (acc_q.size() == 7) begin
            check("midrst_sync", acc_q[0], 8'hAA);
            check("midrst_addr", acc_q[1], 8'h04);
            check("midrst_unread", acc_q[3], 8'h30);
        end

        // random traffic
        clear_on_grant = 1'b0;
        ready_rand = 1'b1;
        for (int n = 0; n < 600; n++) begin
            tick_a();
            if ($urandom_range(0, 7) == 0) begin
                have_msg_bus = N_CH'($urandom_range(0, (1 << N_CH) - 1));
                for (int k = 0; k < N_CH; k++) len_bus[8*k +: 8] = 8'($urandom_range(0, 3));
            end
            tick_b();
        end
        tick_a();
        have_msg_bus = '0;
        tick_b();
        run_packet(200);
        repeat (3) step();
        check("final_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
